// File: rtl/regfile_write_scheduler_if.sv
// Write-port bundle shared by the writeback/debug requesters, the scheduler and the register bank.
interface regfile_write_scheduler_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rw;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ready;
    logic              dbg_valid;
    logic [ADDR_W-1:0] dbg_rw;
    logic [DATA_W-1:0] dbg_data;
    logic              dbg_ready;
    logic              init_done;
    logic              busy;
    logic              rf_reg_write;
    logic [ADDR_W-1:0] rf_rw;
    logic [DATA_W-1:0] rf_busw;

    modport master (
        output wb_valid, wb_rw, wb_data, dbg_valid, dbg_rw, dbg_data,
        input  wb_ready, dbg_ready, init_done, busy, rf_reg_write, rf_rw, rf_busw
    );

    modport slave (
        input  wb_valid, wb_rw, wb_data, dbg_valid, dbg_rw, dbg_data,
        output wb_ready, dbg_ready, init_done, busy, rf_reg_write, rf_rw, rf_busw
    );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the register bank's single write port between a buffered writeback stream and a
// single-shot debug port, after zero-filling the bank; every write is a setup cycle then a strobe.
module regfile_write_scheduler #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                      clk,
    input logic                      reset_n,
    regfile_write_scheduler_if.slave bus
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [2:0] {
        StInitSetup,
        StInitStrobe,
        StIdle,
        StSetup,
        StStrobe
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_init_cnt;
    logic              r_init_done;
    logic [ADDR_W-1:0] r_fifo_rw   [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    logic [CntW-1:0]   r_count;
    logic              r_rf_reg_write;
    logic [ADDR_W-1:0] r_rf_rw;
    logic [DATA_W-1:0] r_rf_busw;

    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic              w_pick;
    logic              w_push;
    logic              w_pop;
    logic              w_dbg_fire;
    logic              w_load;
    logic              w_init_last;
    logic              w_wb_ready;
    logic              w_dbg_ready;
    logic              w_busy;
    logic [ADDR_W-1:0] w_head_rw;
    logic [DATA_W-1:0] w_head_data;
    logic [ADDR_W-1:0] w_load_rw;
    logic [DATA_W-1:0] w_load_data;

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == CntW'(FIFO_DEPTH));
    assign w_head_rw    = r_fifo_rw[r_rd_ptr];
    assign w_head_data  = r_fifo_data[r_rd_ptr];
    assign w_init_last  = (r_init_cnt == {ADDR_W{1'b1}});
    assign w_push       = bus.wb_valid & w_wb_ready;
    assign w_pop        = w_pick & ~w_fifo_empty;
    assign w_dbg_fire   = bus.dbg_valid & w_dbg_ready;

    // Requests to r0 are consumed without a bank write so r0 stays zero.
    always_comb begin
        w_load_rw   = w_pop ? w_head_rw : bus.dbg_rw;
        w_load_data = w_pop ? w_head_data : bus.dbg_data;
        w_load      = (w_pop & (w_head_rw != '0)) |
                      (~w_pop & w_dbg_fire & (bus.dbg_rw != '0));
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StInitSetup;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StInitSetup:  w_state_next = StInitStrobe;
            StInitStrobe: w_state_next = w_init_last ? StIdle : StInitSetup;
            StSetup:      w_state_next = StStrobe;
            StIdle,
            StStrobe:     w_state_next = w_load ? StSetup : StIdle;
            default:      w_state_next = StInitSetup;
        endcase
    end

    // State-decoded combinational outputs.
    always_comb begin
        w_pick      = (r_state == StIdle) || (r_state == StStrobe);
        w_wb_ready  = r_init_done & ~w_fifo_full;
        w_dbg_ready = r_init_done & w_fifo_empty & ~bus.wb_valid & w_pick;
        w_busy      = ~w_fifo_empty | (r_state != StIdle);
    end

    // Registered bank interface; address/data move only when a setup cycle is entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_init_cnt     <= '0;
            r_init_done    <= 1'b0;
            r_rf_reg_write <= 1'b0;
            r_rf_rw        <= '0;
            r_rf_busw      <= '0;
        end else begin
            r_rf_reg_write <= (w_state_next == StStrobe) || (w_state_next == StInitStrobe);
            if (r_state == StInitStrobe) begin
                if (w_init_last) begin
                    r_init_done <= 1'b1;
                end else begin
                    r_init_cnt <= r_init_cnt + ADDR_W'(1);
                    r_rf_rw    <= r_init_cnt + ADDR_W'(1);
                end
            end
            if (w_load) begin
                r_rf_rw   <= w_load_rw;
                r_rf_busw <= w_load_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rw[r_wr_ptr]   <= bus.wb_rw;
            r_fifo_data[r_wr_ptr] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.wb_ready     = w_wb_ready;
    assign bus.dbg_ready    = w_dbg_ready;
    assign bus.busy         = w_busy;
    assign bus.init_done    = r_init_done;
    assign bus.rf_reg_write = r_rf_reg_write;
    assign bus.rf_rw        = r_rf_rw;
    assign bus.rf_busw      = r_rf_busw;
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: an acceptance-order scoreboard and a bank model
// checked on every cycle, plus literal expectations for each scenario.
module tb_regfile_write_scheduler;
    localparam int unsigned DataW      = 32;
    localparam int unsigned AddrW      = 5;
    localparam int          NumRegs    = 32;
    localparam int          InitCycles = 64;

    typedef struct packed {
        logic [AddrW-1:0] rw;
        logic [DataW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n;

    regfile_write_scheduler_if #(.DATA_W(DataW), .ADDR_W(AddrW)) bus ();

    regfile_write_scheduler #(
        .DATA_W    (DataW),
        .ADDR_W    (AddrW),
        .FIFO_DEPTH(4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int               checks = 0;
    int               errors = 0;
    int               cyc;
    int               init_idx = 0;
    int               post_strobes = 0;
    bit               saw_wb_stall = 0;
    wr_t              exp_q[$];
    logic [AddrW-1:0] wr_log[$];
    logic [DataW-1:0] bank[NumRegs];
    logic             prev_strobe = 1'b0;
    logic [AddrW-1:0] prev_rw = '0;
    logic [DataW-1:0] prev_busw = '0;
    wr_t              mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Posedges since reset release.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            init_idx = 0;
        end else begin
            chk("init_done", bus.init_done, cyc >= InitCycles);
            if (cyc < InitCycles) begin
                chk("init_strobe_pattern", bus.rf_reg_write, (cyc % 2) == 1);
                chk("init_wb_ready", bus.wb_ready, 0);
                chk("init_dbg_ready", bus.dbg_ready, 0);
            end
            if (bus.wb_valid) chk("dbg_ready_with_wb", bus.dbg_ready, 0);
            if (bus.rf_reg_write) begin
                chk("strobe_one_cycle", prev_strobe, 0);
                chk("rw_stable", bus.rf_rw, prev_rw);
                chk("busw_stable", bus.rf_busw, prev_busw);
                if (cyc < InitCycles) begin
                    chk("init_rw", bus.rf_rw, init_idx[AddrW-1:0]);
                    chk("init_busw", bus.rf_busw, 0);
                    init_idx++;
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=rw %0d data %0h required=none",
                             bus.rf_rw, bus.rf_busw);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("write_rw", bus.rf_rw, mon_e.rw);
                    chk("write_data", bus.rf_busw, mon_e.data);
                    wr_log.push_back(bus.rf_rw);
                    post_strobes++;
                end
                bank[bus.rf_rw] = bus.rf_busw;
            end
            if (cyc == InitCycles) chk("init_reg_count", init_idx, NumRegs);
            if (bus.wb_valid && !bus.wb_ready && cyc >= InitCycles) saw_wb_stall = 1;
            if (bus.wb_valid && bus.wb_ready && bus.wb_rw != '0)
                exp_q.push_back({bus.wb_rw, bus.wb_data});
            if (bus.dbg_valid && bus.dbg_ready && bus.dbg_rw != '0)
                exp_q.push_back({bus.dbg_rw, bus.dbg_data});
        end
        prev_strobe = bus.rf_reg_write;
        prev_rw     = bus.rf_rw;
        prev_busw   = bus.rf_busw;
    end

    task automatic wb_send(input logic [AddrW-1:0] rw, input logic [DataW-1:0] data);
        bit done = 0;
        bus.wb_valid = 1'b1;
        bus.wb_rw    = rw;
        bus.wb_data  = data;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.wb_ready) done = 1;
            @(posedge clk);
            #1;
        end
        bus.wb_valid = 1'b0;
        if (!done) fail_timeout("wb_send");
    endtask

    task automatic dbg_send(input logic [AddrW-1:0] rw, input logic [DataW-1:0] data);
        bit done = 0;
        bus.dbg_valid = 1'b1;
        bus.dbg_rw    = rw;
        bus.dbg_data  = data;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.dbg_ready) done = 1;
            @(posedge clk);
            #1;
        end
        bus.dbg_valid = 1'b0;
        if (!done) fail_timeout("dbg_send");
    endtask

    task automatic wait_init();
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.init_done) done = 1;
        end
        if (!done) fail_timeout("wait_init");
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!bus.busy) done = 1;
        end
        if (!done) fail_timeout("wait_idle");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_rw     = '0;
        bus.wb_data   = '0;
        bus.dbg_valid = 1'b0;
        bus.dbg_rw    = '0;
        bus.dbg_data  = '0;
        #1;
        chk("reset_strobe", bus.rf_reg_write, 0);
        chk("reset_rw", bus.rf_rw, 0);
        chk("reset_busw", bus.rf_busw, 0);
        chk("reset_init_done", bus.init_done, 0);
        chk("reset_wb_ready", bus.wb_ready, 0);
        chk("reset_dbg_ready", bus.dbg_ready, 0);
        chk("reset_busy", bus.busy, 1);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;

        wait_init();
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        chk("idle_wb_ready", bus.wb_ready, 1);
        chk("idle_dbg_ready", bus.dbg_ready, 1);
        chk("zero_fill_r31", bank[31], 32'h0);

        // Single writeback: setup cycle then a one-cycle strobe with unchanged data.
        @(posedge clk);
        #1;
        wb_send(5'd5, 32'hDEAD_BEEF);
        begin
            bit seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (bus.rf_rw == 5'd5 && !bus.rf_reg_write) seen = 1;
            end
            if (!seen) fail_timeout("single_setup");
        end
        chk("single_setup_data", bus.rf_busw, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("single_strobe", bus.rf_reg_write, 1);
        chk("single_strobe_rw", bus.rf_rw, 5);
        chk("single_strobe_data", bus.rf_busw, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("single_strobe_end", bus.rf_reg_write, 0);
        wait_idle();

        // Back-to-back writebacks fill the FIFO and drain in order.
        @(posedge clk);
        #1;
        for (int i = 1; i <= 8; i++) wb_send(AddrW'(i), 32'h100 + i);
        wait_idle();
        chk("burst_backpressure", saw_wb_stall, 1);
        chk("burst_r1", bank[1], 32'h101);
        chk("burst_r8", bank[8], 32'h108);

        // Debug waits for the writeback.
        @(posedge clk);
        #1;
        fork
            wb_send(5'd4, 32'h22);
            dbg_send(5'd3, 32'h11);
        join
        wait_idle();
        chk("prio_first", wr_log[wr_log.size()-2], 4);
        chk("prio_second", wr_log[wr_log.size()-1], 3);
        chk("prio_r4", bank[4], 32'h22);
        chk("prio_r3", bank[3], 32'h11);

        // r0 is consumed without a bank write.
        @(posedge clk);
        #1;
        wb_send(5'd0, 32'hFFFF_FFFF);
        wb_send(5'd2, 32'h7);
        wait_idle();
        chk("r0_untouched", bank[0], 32'h0);
        chk("r2_written", bank[2], 32'h7);
        chk("last_write_r2", wr_log[wr_log.size()-1], 2);
        chk("write_count", post_strobes, 12);

        // Reset during a strobe with entries still queued.
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) wb_send(AddrW'(10 + i), 32'hA0 + i);
        begin
            bit seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (bus.rf_reg_write) seen = 1;
            end
            if (!seen) fail_timeout("strobe_before_reset");
        end
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_strobe", bus.rf_reg_write, 0);
        chk("midreset_busy", bus.busy, 1);
        chk("midreset_init_done", bus.init_done, 0);
        chk("midreset_wb_ready", bus.wb_ready, 0);
        chk("midreset_rw", bus.rf_rw, 0);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        wait_init();
        repeat (5) @(negedge clk);
        chk("post_reset_busy", bus.busy, 0);
        chk("post_reset_queue", exp_q.size(), 0);
        chk("post_reset_r10", bank[10], 32'h0);
        chk("post_reset_r5", bank[5], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Owns the single write port of the 32x32 register bank. The bank captures data on the rising edge of its write strobe.
- Shares that port between two requesters: the writeback stage (primary, buffered in a FIFO) and the debug/loader interface (secondary, single-shot).
- After reset, sequences a zero-fill of all registers before any requester is served.
- Produces a clean setup-then-strobe pulse so address and data are stable before the bank's strobe edge.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width (2**ADDR_W registers)
FIFO_DEPTH, 4, writeback request buffer entries (power of 2, >=2)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
wb_valid  input  1  writeback write request
wb_rw  input  ADDR_W  writeback destination register
wb_data  input  DATA_W  writeback data
wb_ready  output  1  writeback request accepted when wb_valid & wb_ready
dbg_valid  input  1  debug write request
dbg_rw  input  ADDR_W  debug destination register
dbg_data  input  DATA_W  debug data
dbg_ready  output  1  debug request accepted when dbg_valid & dbg_ready
init_done  output  1  zero-fill complete
busy  output  1  FIFO non-empty or state not IDLE
rf_reg_write  output  1  write strobe to register bank
rf_rw  output  ADDR_W  write address to register bank
rf_busw  output  DATA_W  write data to register bank

Behaviour:
- Reset (async, reset_n=0): state=INIT_SETUP, init counter=0, FIFO empty, init_done=0, rf_reg_write=0, rf_rw=0, rf_busw=0, wb_ready=0, dbg_ready=0, busy=1.
- All outputs are registered except wb_ready, dbg_ready and busy, which are combinational from state.
- States: INIT_SETUP, INIT_STROBE, IDLE, SETUP, STROBE.
- INIT_SETUP:
  - rf_rw=counter, rf_busw=0, rf_reg_write=0.
  - Goes to INIT_STROBE.
- INIT_STROBE:
  - rf_reg_write=1.
  - If counter==2**ADDR_W-1: set init_done=1 and go to IDLE.
  - Otherwise: counter+1 and go to INIT_SETUP.
  - Zero-fill takes 2*2**ADDR_W cycles (64 at default), r0 included.
- SETUP:
  - rf_rw/rf_busw were loaded on entry; rf_reg_write=0.
  - Goes to STROBE.
- STROBE:
  - rf_reg_write=1 for exactly one cycle.
  - Next state is chosen by the pick rule below, else IDLE.
- IDLE: next state chosen by the pick rule.
- Pick rule (IDLE or STROBE), first match wins:
  - FIFO non-empty: pop head, load rf_rw/rf_busw, go to SETUP.
  - Else debug handshake this cycle: load dbg fields, go to SETUP.
- Address 0: any request to register 0 is accepted and popped/consumed, but no SETUP/STROBE occurs. r0 stays zero.
  - A popped r0 entry costs one cycle in the pick state; the next pick happens the following cycle.
- Throughput: one write per 2 cycles sustained. rf_rw/rf_busw change only on entry to SETUP (or INIT_SETUP) and are stable for the full strobe high time.
- wb_ready = init_done & FIFO not full.
- FIFO ordering:
  - Strict FIFO order.
  - Simultaneous push and pop in the same cycle is legal, occupancy unchanged.
  - A push on the cycle the FIFO becomes non-full is accepted (wb_ready is evaluated on the current count).
- dbg_ready = init_done & FIFO empty & wb_valid=0 & state in {IDLE, STROBE}. Writeback always has priority; debug never preempts queued writebacks.
- No write-after-write reordering: writes reach the bank in acceptance order (writebacks in FIFO order; debug only when the FIFO is drained).
- Reset mid-operation: any in-flight strobe is cut to 0 immediately, the FIFO is flushed and zero-fill restarts from register 0.
- Requests presented while init_done=0 are not accepted (ready low) and must be held by the requester.

Test Plan:
- Release reset -> rf_reg_write pulses 32 times, with rf_rw 0..31 and rf_busw=0 on each pulse; init_done rises at cycle 64 after reset release; wb_ready stays 0 throughout.
- After init, push wb (rw=5, data=0xDEADBEEF) -> next cycle SETUP with rf_rw=5, rf_busw=0xDEADBEEF, strobe 0; following cycle strobe 1 for one cycle, data unchanged.
- Push writebacks every cycle to rw=1..8 -> wb_ready drops when 4 are queued; strobes arrive every 2 cycles in order 1..8, none lost.
- Assert dbg_valid (rw=3, data=0x11) and wb_valid (rw=4, data=0x22) together -> wb to 4 is written first; dbg_ready is 0 until the FIFO is empty and wb_valid is low; then 3 <= 0x11.
- wb to rw=0 (data=0xFFFFFFFF) followed by rw=2 (data=0x7) -> no strobe for r0; strobe for r2 with data 0x7.
- Assert reset_n=0 while in STROBE with 3 FIFO entries queued -> rf_reg_write=0 immediately and FIFO empty; after release, full 64-cycle zero-fill and no stale writes.
